// File: rtl/usb_sdi_tx.sv
// Avalon-MM slave that serialises bytes MSB first onto sclk/sdi (SPI mode 0).
// Software drives cs_n via CONTROL; done/overrun events can raise a level interrupt.
module usb_sdi_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sclk,
  output logic        sdi,
  output logic        cs_n,
  output logic        irq
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_div_cnt;
  logic [7:0]  w_div_cnt_nxt;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_txdata;
  logic [1:0]  r_ctrl;
  logic        r_done;
  logic        r_overrun;
  logic [31:0] r_readdata;
  logic [31:0] w_rdata;

  logic w_wr;
  logic w_tx_wr;
  logic w_ctrl_wr;
  logic w_ev_wr;
  logic w_busy;
  logic w_accept;
  logic w_overrun_set;
  logic w_done_set;
  logic w_div_end;
  logic w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_tx_wr   = w_wr & (address == 2'd0);
  assign w_ctrl_wr = w_wr & (address == 2'd2);
  assign w_ev_wr   = w_wr & (address == 2'd3);
  assign w_busy    = (r_state != StIdle);
  assign w_div_end = (r_div_cnt == DivLast);

  // A write landing on the completing edge still sees a busy FSM, so it is rejected.
  assign w_accept      = w_tx_wr & ~w_busy;
  assign w_overrun_set = w_tx_wr & w_busy;

  assign w_unused_wdata = ^writedata[31:8];

  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_done_set    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt   = StLow;
          w_div_cnt_nxt = 8'd0;
          w_bit_cnt_nxt = 3'd0;
          w_shift_nxt   = writedata[7:0];
        end
      end
      StLow: begin
        if (w_div_end) begin
          w_state_nxt   = StHigh;
          w_div_cnt_nxt = 8'd0;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      StHigh: begin
        if (w_div_end) begin
          w_div_cnt_nxt = 8'd0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = StIdle;
            w_bit_cnt_nxt = 3'd0;
            w_done_set    = 1'b1;
          end else begin
            // Shifting only here keeps sdi stable across the whole high phase.
            w_state_nxt   = StLow;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {r_shift[6:0], 1'b0};
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[7:0] = r_txdata;
      2'd1:    w_rdata[2:0] = {r_overrun, r_done, w_busy};
      2'd2:    w_rdata[1:0] = r_ctrl;
      2'd3:    w_rdata[1:0] = {r_overrun, r_done};
      default: w_rdata      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_div_cnt  <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_txdata   <= 8'd0;
      r_ctrl     <= 2'd0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      if (w_accept) begin
        r_txdata <= writedata[7:0];
      end
      if (w_ctrl_wr) begin
        r_ctrl <= writedata[1:0];
      end
      // Set beats a coincident clear from an EVENT write.
      r_done     <= w_done_set | (r_done & ~w_ev_wr);
      r_overrun  <= w_overrun_set | (r_overrun & ~w_ev_wr);
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign sclk     = (r_state == StHigh);
  assign sdi      = (r_state == StIdle) ? 1'b1 : r_shift[7];
  assign cs_n     = ~r_ctrl[0];
  assign irq      = r_done & r_ctrl[1];

endmodule

// File: tb/tb_usb_sdi_tx.sv
// Directed bench for usb_sdi_tx: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_usb_sdi_tx;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sclk;
  logic        sdi;
  logic        cs_n;
  logic        irq;

  logic        b_cs;
  logic [1:0]  b_addr;
  logic        b_wn;
  logic [31:0] b_wd;
  logic [31:0] b_rd;
  logic        b_sclk;
  logic        b_sdi;
  logic        b_csn;
  logic        b_irq;

  int checks;
  int failures;

  usb_sdi_tx #(.CLK_DIV(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .sclk      (sclk),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .irq       (irq)
  );

  usb_sdi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .chipselect(b_cs),
    .address   (b_addr),
    .write_n   (b_wn),
    .writedata (b_wd),
    .readdata  (b_rd),
    .sclk      (b_sclk),
    .sdi       (b_sdi),
    .cs_n      (b_csn),
    .irq       (b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write on the next edge, then return the bus to STATUS reads.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
  endtask

  // Samples the CLK_DIV=4 line for ncyc cycles; optionally issues a TXDATA write.
  task automatic monitor4(input int ncyc, input int wr_at, input logic [7:0] wr_data,
                          output int pulses, output logic [7:0] rx, output int width_err,
                          output int busy_cnt, output logic [31:0] st_mid);
    logic prev;
    logic held;
    int   hrun;
    int   lrun;
    pulses = 0; rx = 8'h00; width_err = 0; busy_cnt = 0; st_mid = 32'h0;
    prev = 1'b0; held = 1'b0; hrun = 0; lrun = 1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (wr_at == 0 && readdata[0]) busy_cnt++;
      if (i == wr_at + 2) st_mid = readdata;
      if (sclk && !prev) begin
        pulses++;
        rx = {rx[6:0], sdi};
        held = sdi;
        if (lrun != 4) width_err++;
        hrun = 1;
      end else if (sclk && prev) begin
        hrun++;
        if (sdi != held) width_err++;
      end else if (!sclk && prev) begin
        if (hrun != 4) width_err++;
        lrun = 1;
      end else begin
        lrun++;
      end
      prev = sclk;
      if (i == wr_at) begin
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = {24'h0, wr_data};
      end else begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0);
    end
    checks++;
    if ({sclk, sdi, cs_n, irq} !== 4'b0110) begin
      failures++; $display("FAIL reset_pins got=%b exp=%b", {sclk, sdi, cs_n, irq}, 4'b0110);
    end
    checks++;
    if ({b_sclk, b_sdi, b_csn, b_irq, b_rd} !== {4'b0110, 32'h0}) begin
      failures++; $display("FAIL reset_div1 got=%b/%h exp=0110/0", {b_sclk, b_sdi, b_csn, b_irq},
                           b_rd);
    end
  endtask

  task automatic test_transfer();
    int pulses, werr, busy;
    logic [7:0] rx;
    logic [31:0] st;
    bus_write(2'd0, 32'hA5);
    checks++;
    if ({sclk, sdi} !== 2'b01) begin
      failures++; $display("FAIL xfer_first got=%b exp=%b", {sclk, sdi}, 2'b01);
    end
    monitor4(80, 0, 8'h00, pulses, rx, werr, busy, st);
    checks++;
    if (pulses != 8) begin
      failures++; $display("FAIL xfer_pulses got=%0d exp=8", pulses);
    end
    checks++;
    if (rx !== 8'hA5) begin
      failures++; $display("FAIL xfer_bits got=%h exp=a5", rx);
    end
    checks++;
    if (werr != 0) begin
      failures++; $display("FAIL xfer_widths got=%0d exp=0", werr);
    end
    checks++;
    if (busy != 64) begin
      failures++; $display("FAIL xfer_busy got=%0d exp=64", busy);
    end
    checks++;
    if (readdata !== 32'h2) begin
      failures++; $display("FAIL xfer_status_end got=%h exp=2", readdata);
    end
    address = 2'd3;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h1) begin
      failures++; $display("FAIL xfer_event got=%h exp=1", readdata);
    end
    address = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'hA5) begin
      failures++; $display("FAIL xfer_txdata got=%h exp=a5", readdata);
    end
  endtask

  task automatic test_overrun();
    int pulses, werr, busy;
    logic [7:0] rx;
    logic [31:0] st;
    bus_write(2'd0, 32'hA5);
    monitor4(80, 10, 8'h3C, pulses, rx, werr, busy, st);
    checks++;
    if (pulses != 8 || rx !== 8'hA5 || werr != 0) begin
      failures++; $display("FAIL ovr_line got=%0d/%h/%0d exp=8/a5/0", pulses, rx, werr);
    end
    checks++;
    if (st !== 32'h7) begin
      failures++; $display("FAIL ovr_status_busy got=%h exp=7", st);
    end
    address = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'hA5) begin
      failures++; $display("FAIL ovr_txdata got=%h exp=a5", readdata);
    end
    address = 2'd1;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h6) begin
      failures++; $display("FAIL ovr_status_idle got=%h exp=6", readdata);
    end
    address = 2'd3;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h3) begin
      failures++; $display("FAIL ovr_event got=%h exp=3", readdata);
    end
  endtask

  task automatic test_irq();
    int pulses, werr, busy;
    logic [7:0] rx;
    logic [31:0] st;
    bus_write(2'd3, 32'h0);
    bus_write(2'd2, 32'h3);
    checks++;
    if ({cs_n, irq} !== 2'b00) begin
      failures++; $display("FAIL irq_ctrl got=%b exp=00", {cs_n, irq});
    end
    address = 2'd2;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h3) begin
      failures++; $display("FAIL irq_ctrl_read got=%h exp=3", readdata);
    end
    bus_write(2'd0, 32'h81);
    monitor4(70, 0, 8'h00, pulses, rx, werr, busy, st);
    checks++;
    if (rx !== 8'h81 || {cs_n, irq} !== 2'b01) begin
      failures++; $display("FAIL irq_done got=%h/%b exp=81/01", rx, {cs_n, irq});
    end
    bus_write(2'd3, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_event_collision();
    bus_write(2'd0, 32'h55);
    repeat (63) begin @(posedge clk); #1; end
    checks++;
    if (sclk !== 1'b1) begin
      failures++; $display("FAIL coll_last_high got=%b exp=1", sclk);
    end
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if ({irq, sclk, sdi} !== 3'b101) begin
      failures++; $display("FAIL coll_edge got=%b exp=101", {irq, sclk, sdi});
    end
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h1) begin
      failures++; $display("FAIL coll_event got=%h exp=1", readdata);
    end
  endtask

  task automatic test_tx_on_done_edge();
    bus_write(2'd3, 32'h0);
    bus_write(2'd0, 32'h12);
    repeat (63) begin @(posedge clk); #1; end
    chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h34;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    checks++;
    if ({sclk, sdi} !== 2'b01) begin
      failures++; $display("FAIL edge_idle got=%b exp=01", {sclk, sdi});
    end
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (sclk !== 1'b0 || readdata !== 32'h3) begin
      failures++; $display("FAIL edge_reject got=%b/%h exp=0/3", sclk, readdata);
    end
    address = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h12) begin
      failures++; $display("FAIL edge_txdata got=%h exp=12", readdata);
    end
  endtask

  task automatic test_mid_reset();
    bus_write(2'd0, 32'hF0);
    repeat (19) begin @(posedge clk); #1; end
    checks++;
    if ({cs_n, irq} !== 2'b01) begin
      failures++; $display("FAIL rst_before got=%b exp=01", {cs_n, irq});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sclk, sdi, cs_n, irq} !== 4'b0110) begin
      failures++; $display("FAIL rst_abort got=%b exp=0110", {sclk, sdi, cs_n, irq});
    end
    reset = 1'b0;
    address = 2'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (readdata !== 32'h0 || sclk !== 1'b0) begin
      failures++; $display("FAIL rst_status got=%h/%b exp=0/0", readdata, sclk);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, busy, first_hi, last_hi;
    logic [15:0] rx;
    pulses = 0; busy = 0; first_hi = -1; last_hi = -1; rx = 16'h0;
    b_cs = 1'b1; b_wn = 1'b0; b_addr = 2'd0; b_wd = 32'hFF;
    @(posedge clk); #1;
    b_cs = 1'b0; b_wn = 1'b1; b_addr = 2'd1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i != 17 && b_rd[0]) busy++;
      if (b_sclk) begin
        pulses++;
        rx = {rx[14:0], b_sdi};
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
      if (i == 16) begin
        checks++;
        if ({b_sclk, b_sdi} !== 2'b01) begin
          failures++; $display("FAIL b2b_gap got=%b exp=01", {b_sclk, b_sdi});
        end
        b_cs = 1'b1; b_wn = 1'b0; b_addr = 2'd0; b_wd = 32'h00;
      end else begin
        b_cs = 1'b0; b_wn = 1'b1; b_addr = 2'd1;
      end
    end
    checks++;
    if (pulses != 16 || rx !== 16'hFF00) begin
      failures++; $display("FAIL b2b_bits got=%0d/%h exp=16/ff00", pulses, rx);
    end
    checks++;
    if (first_hi != 1 || last_hi != 32 || busy != 32) begin
      failures++; $display("FAIL b2b_timing got=%0d/%0d/%0d exp=1/32/32", first_hi, last_hi, busy);
    end
    b_addr = 2'd3;
    @(posedge clk); #1;
    checks++;
    if (b_rd !== 32'h1) begin
      failures++; $display("FAIL b2b_event got=%h exp=1", b_rd);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
    b_cs = 1'b0; b_wn = 1'b1; b_addr = 2'd0; b_wd = 32'h0;
    test_reset();
    test_transfer();
    test_overrun();
    test_irq();
    test_event_collision();
    test_tx_on_done_edge();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_sdi_tx.md
USB_SDI_TX -- requirements
Module: usb_sdi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, gives the clk cycles per sclk half-period; legal range 1..255.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 chipselect  input  1  Avalon-MM slave select.
REQ-005 address  input  2  register select: 0 TXDATA, 1 STATUS, 2 CONTROL, 3 EVENT.
REQ-006 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-007 writedata  input  32  write data; only the bits defined per register are used.
REQ-008 readdata  output  32  registered read data; undefined bits read 0.
REQ-009 sclk  output  1  serial clock to the USB controller; idles low.
REQ-010 sdi  output  1  serial data to the USB controller, MSB first; idles high.
REQ-011 cs_n  output  1  chip select to the USB controller, software controlled.
REQ-012 irq  output  1  level interrupt = EVENT.done & CONTROL.irq_en.

Function
REQ-013 A write is wr = chipselect & ~write_n; a register write SHALL take effect on the clk edge where wr is high.
REQ-014 The block SHALL update readdata every cycle from the address presented that cycle, giving 1-cycle read latency, independent of chipselect.
REQ-015 TXDATA write: if idle, latch writedata[7:0] into the shift register and start a transfer; if busy, ignore the data and set EVENT.overrun.
REQ-016 TXDATA read SHALL return the last accepted byte in bits [7:0].
REQ-017 STATUS read SHALL return bit0 busy, bit1 EVENT.done, bit2 EVENT.overrun; STATUS writes SHALL be ignored.
REQ-018 CONTROL bit0 cs_assert SHALL drive cs_n = ~cs_assert; bit1 irq_en; read SHALL return both bits.
REQ-019 EVENT read SHALL return bit0 done, bit1 overrun; any EVENT write SHALL clear both flags.
REQ-020 The FSM SHALL have states IDLE, LOW and HIGH; busy = (state != IDLE).
REQ-021 IDLE->LOW on an accepted TXDATA write; in the following cycle busy=1, sclk=0 and sdi=byte[7].
REQ-022 LOW and HIGH SHALL each last exactly CLK_DIV cycles, counted by div_cnt.
REQ-023 sclk SHALL be 1 only in HIGH.
REQ-024 sdi SHALL change only on entry to LOW (mode 0: stable across each rising sclk edge).
REQ-025 HIGH->LOW with the next bit while bit_cnt<7; HIGH->IDLE after bit 7.
REQ-026 A transfer SHALL occupy busy for exactly 16*CLK_DIV cycles.
REQ-027 On the HIGH->IDLE transition: sclk->0, sdi->1, busy->0 and EVENT.done->1, all on the same edge.
REQ-028 If an EVENT write coincides with a done or overrun set, the set SHALL win.
REQ-029 A TXDATA write on the same edge that returns the FSM to IDLE is treated as busy: it SHALL be rejected and SHALL set overrun.
REQ-030 cs_n SHALL be independent of the FSM; changing CONTROL mid-transfer SHALL NOT abort or alter the transfer.

Reset
REQ-031 While reset=1 the block SHALL force state=IDLE, div_cnt=0, bit_cnt=0, shift register=0, CONTROL=0 and EVENT=0.
REQ-032 On the first edge after reset deasserts: readdata=0, sclk=0, sdi=1, cs_n=1, irq=0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer on that edge without setting done.

Verification
REQ-034 CLK_DIV=4; write TXDATA 0xA5 -> 8 sclk pulses, each 4 cycles high and 4 low; sdi samples 1,0,1,0,0,1,0,1 at rising edges; busy for 64 cycles; then EVENT.done=1.
REQ-035 Second TXDATA write (0x3C) while busy -> the line shows only 0xA5; TXDATA reads 0xA5; STATUS reads 0x7 while busy, 0x6 after completion.
REQ-036 CONTROL=0x3 and complete a transfer -> irq=1 and cs_n=0; EVENT write -> irq=0 on the next cycle; the same write on the completion edge -> done remains 1.
REQ-037 Assert reset at cycle 20 of a transfer -> next cycle sclk=0, sdi=1, busy=0, done=0, cs_n=1.
REQ-038 CLK_DIV=1 with 0xFF then 0x00 back-to-back (second write issued the cycle after busy falls) -> each transfer takes 16 cycles; sdi is correct; no overrun.
